// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module   : async_fifo_pkg
// Brief    : Shared constants, lock-state encoding and helper functions for
//            the async_fifo family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

    localparam int c_dsize = 32;
    localparam int c_asize = 4;

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_state_t;

    // A one-bit index is still needed when only two requesters exist.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/async_fifo_wr_arb_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: rotate the request vector by
//            the pointer, take the lowest set bit, then unrotate the index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  winner,
    output logic            found
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW-1:0]    w_offset;
    logic [IDW:0]      w_sum;

    assign w_dbl = {req, req} >> rr_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_offset = '0;
        found    = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_offset = IDW'(i);
                found    = 1'b1;
            end
        end
    end

    // Pointer and offset are both below NREQ, so one conditional subtract wraps.
    assign w_sum  = {1'b0, rr_ptr} + {1'b0, w_offset};
    assign winner = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                              : w_sum[IDW-1:0];

endmodule

`default_nettype wire

// File: rtl/async_fifo_wr_arb.sv
// ============================================================================
// Module   : async_fifo_wr_arb
// Brief    : Round-robin arbiter sharing the async_fifo write port among NREQ
//            valid/ready requesters. Optional ASYNC_FIFO_ARB_PACKET_LOCK_EN
//            keeps the grant on one requester until its req_last word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo_wr_arb
    import async_fifo_pkg::*;
#(
    parameter int DSIZE = c_dsize,
    parameter int NREQ  = 4,
    parameter int IDW   = clog2_min1(NREQ),
    parameter int CNTW  = 32
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    input  logic                  wfull,
    output logic [IDW-1:0]        grant_id,
    output logic                  grant_vld,
    output logic [CNTW-1:0]       wr_count
);

    // Requests are ignored while reset is held so nothing is granted.
    logic [NREQ-1:0] w_req_ok;
    assign w_req_ok = req_valid & {NREQ{~wrst}};

    logic [IDW-1:0]  r_rr_ptr_q, w_rr_ptr_d;
    logic [IDW-1:0]  r_grant_id_q, w_grant_id_d;
    logic [CNTW-1:0] r_wr_count_q, w_wr_count_d;
    logic [IDW-1:0]  w_pick_id, w_winner;
    logic            w_pick_found, w_adv;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (w_req_ok),
        .rr_ptr (r_rr_ptr_q),
        .winner (w_pick_id),
        .found  (w_pick_found)
    );

`ifdef ASYNC_FIFO_ARB_PACKET_LOCK_EN
    lock_state_t    r_lock_q, w_lock_d;
    logic [IDW-1:0] r_lock_id_q, w_lock_id_d;

    always_comb begin
        w_winner  = w_pick_id;
        grant_vld = w_pick_found;
        if (r_lock_q == ARB_LOCKED) begin
            w_winner  = r_lock_id_q;
            grant_vld = w_req_ok[r_lock_id_q];
        end
    end

    // Only the closing word of a packet releases the lock and moves the pointer.
    always_comb begin
        w_lock_d    = r_lock_q;
        w_lock_id_d = r_lock_id_q;
        w_adv       = winc;
        if (winc) begin
            if (req_last[w_winner]) begin
                w_lock_d = ARB_OPEN;
            end else begin
                w_lock_d    = ARB_LOCKED;
                w_lock_id_d = w_winner;
                w_adv       = 1'b0;
            end
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_lock_q    <= ARB_OPEN;
            r_lock_id_q <= '0;
        end else begin
            r_lock_q    <= w_lock_d;
            r_lock_id_q <= w_lock_id_d;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^req_last;
    assign w_winner      = w_pick_id;
    assign grant_vld     = w_pick_found;
    assign w_adv         = winc;
`endif

    assign winc     = grant_vld & ~wfull;
    assign wdata    = req_data[w_winner*DSIZE +: DSIZE];
    assign grant_id = grant_vld ? w_winner : r_grant_id_q;
    assign wr_count = r_wr_count_q;

    for (genvar k = 0; k < NREQ; k++) begin : g_ready
        assign req_ready[k] = winc && (w_winner == IDW'(k));
    end

    always_comb begin
        w_rr_ptr_d   = r_rr_ptr_q;
        w_grant_id_d = grant_vld ? w_winner : r_grant_id_q;
        w_wr_count_d = r_wr_count_q;
        if (w_adv) begin
            w_rr_ptr_d = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);
        end
        if (winc && (r_wr_count_q != '1)) begin
            w_wr_count_d = r_wr_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_rr_ptr_q   <= '0;
            r_grant_id_q <= '0;
            r_wr_count_q <= '0;
        end else begin
            r_rr_ptr_q   <= w_rr_ptr_d;
            r_grant_id_q <= w_grant_id_d;
            r_wr_count_q <= w_wr_count_d;
        end
    end

endmodule

`default_nettype wire
